// File: rtl/if_stage.sv
// if_stage: instruction fetch with fetch PC, bus requester, output register and one-entry skid buffer
module if_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_ibus_req,
  output logic [XLEN-1:0] o_ibus_addr,
  input  logic            i_ibus_ack,
  input  logic [31:0]     i_ibus_data,
  input  logic            i_ibus_err,
  output logic            o_valid,
  output logic [31:0]     o_inst,
  output logic [XLEN-1:0] o_pc,
  output logic            o_fault
);
  typedef enum logic [1:0] {IDLE, FETCH, FLUSH, HALT} state_t;
  state_t          state;
  logic [XLEN-1:0] pc, flush_addr, skid_pc;
  logic [31:0]     skid_inst, new_inst;
  logic            skid_v, skid_fault;
  logic            misal, issue, fetch_ack, new_v, new_fault, consume, take;
  assign misal       = |pc[1:0];
  assign issue       = state == FETCH && !skid_v;
  // FLUSH keeps presenting the abandoned request until the bus acks it
  assign o_ibus_req  = (issue && !misal) || state == FLUSH;
  assign o_ibus_addr = state == FLUSH ? flush_addr : pc;
  assign fetch_ack   = issue && !misal && i_ibus_ack;
  assign new_v       = issue && (misal || i_ibus_ack);
  assign new_fault   = misal || i_ibus_err;
  assign new_inst    = new_fault ? NOP_INST : i_ibus_data;
  assign consume     = o_valid && !i_stall;
  assign take        = consume || !o_valid;
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      flush_addr <= RESET_PC;
      skid_v     <= 1'b0;
      skid_inst  <= NOP_INST;
      skid_pc    <= RESET_PC;
      skid_fault <= 1'b0;
      o_valid    <= 1'b0;
      o_inst     <= NOP_INST;
      o_pc       <= RESET_PC;
      o_fault    <= 1'b0;
    end else if (i_redirect) begin
      state      <= (o_ibus_req && !i_ibus_ack) ? FLUSH : FETCH;
      flush_addr <= o_ibus_addr;
      pc         <= i_redirect_pc;
      skid_v     <= 1'b0;
      o_valid    <= 1'b0;
      o_inst     <= NOP_INST;
      o_fault    <= 1'b0;
    end else begin
      state <= state == IDLE ? FETCH :
               (state == FLUSH && i_ibus_ack) ? FETCH :
               (new_v && new_fault) ? HALT : state;
      if (fetch_ack) pc <= pc + XLEN'(4);
      if (take) begin
        if (skid_v) begin
          o_valid <= 1'b1;
          o_inst  <= skid_inst;
          o_pc    <= skid_pc;
          o_fault <= skid_fault;
          skid_v  <= 1'b0;
        end else if (new_v) begin
          o_valid <= 1'b1;
          o_inst  <= new_inst;
          o_pc    <= pc;
          o_fault <= new_fault;
        end else if (consume) begin
          o_valid <= 1'b0;
          o_inst  <= NOP_INST;
          o_fault <= 1'b0;
        end
      end else if (new_v) begin
        skid_v     <= 1'b1;
        skid_inst  <= new_inst;
        skid_pc    <= pc;
        skid_fault <= new_fault;
      end
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed scenarios then randomized bus/stall/redirect traffic against a stream model
module tb_if_stage;
  localparam logic [31:0] K   = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0, rstn, stall, redirect, ack, err, req, valid, fault;
  logic [31:0] redirect_pc, addr, data, inst, pc;
  int          n_chk = 0, n_err = 0, n_cons = 0, lat = 0;
  logic        pend, halted, prev_redir, exp_f, s, r, a, e;
  logic [31:0] pend_addr, exp_pc, tgt, d;
  int          sel;
  always #5 clk = ~clk;
  if_stage dut (
    .i_clk(clk), .i_rstn(rstn), .i_stall(stall), .i_redirect(redirect),
    .i_redirect_pc(redirect_pc), .o_ibus_req(req), .o_ibus_addr(addr),
    .i_ibus_ack(ack), .i_ibus_data(data), .i_ibus_err(err),
    .o_valid(valid), .o_inst(inst), .o_pc(pc), .o_fault(fault)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic ds, dr, input logic [31:0] drpc, input logic da,
                       input logic [31:0] dd, input logic de);
    stall = ds; redirect = dr; redirect_pc = drpc; ack = da; data = dd; err = de;
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  initial begin
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) tick;
    check("rst_req", req, 0);
    check("rst_valid", valid, 0);
    check("rst_fault", fault, 0);
    check("rst_inst", inst, NOP);
    check("rst_pc", pc, 0);
    rstn = 1'b1;
    check("idle_req", req, 0);
    for (int i = 1; i <= 6; i++) begin
      tick;
      check("tp_req", req, 1);
      check("tp_addr", addr, 32'(4 * (i - 1)));
      if (i >= 2) begin
        check("tp_valid", valid, 1);
        check("tp_pc", pc, 32'(4 * (i - 2)));
        check("tp_inst", inst, 32'(4 * (i - 2)) ^ K);
      end
      drive(0, 0, 0, 1, addr ^ K, 0);
    end
    tick;
    check("sk_pc0", pc, 20);
    drive(1, 0, 0, 1, 32'd24 ^ K, 0);
    for (int j = 0; j < 3; j++) begin
      tick;
      check("sk_noreq", req, 0);
      check("sk_hold_pc", pc, 20);
      check("sk_hold_valid", valid, 1);
      drive(j < 2, 0, 0, 0, 0, 0);
    end
    tick;
    check("sk_drain_pc", pc, 24);
    check("sk_drain_inst", inst, 32'd24 ^ K);
    check("sk_resume_addr", addr, 28);
    drive(0, 0, 0, 1, 32'd28 ^ K, 0);
    tick;
    check("sk_next_pc", pc, 28);
    drive(0, 1, 32'h10, 1, 32'hBAD0_0000, 0);
    tick;
    check("rd_valid", valid, 0);
    check("rd_addr", addr, 32'h10);
    drive(0, 1, 32'h200, 0, 0, 0);
    repeat (2) begin
      tick;
      check("fl_valid", valid, 0);
      check("fl_req", req, 1);
      check("fl_addr", addr, 32'h10);
      drive(0, 0, 0, 0, 0, 0);
    end
    drive(0, 0, 0, 1, 32'hDEAD_BEEF, 0);
    tick;
    check("fl_done_valid", valid, 0);
    check("fl_new_addr", addr, 32'h200);
    drive(0, 0, 0, 1, 32'h200 ^ K, 0);
    tick;
    check("fl_out_pc", pc, 32'h200);
    check("fl_out_inst", inst, 32'h200 ^ K);
    drive(1, 0, 0, 1, 32'h204 ^ K, 0);
    tick;
    check("rs_noreq", req, 0);
    drive(1, 1, 32'h400, 0, 0, 0);
    tick;
    check("rs_valid", valid, 0);
    check("rs_addr", addr, 32'h400);
    drive(0, 0, 0, 1, 32'h400 ^ K, 0);
    tick;
    check("rs_pc", pc, 32'h400);
    drive(0, 1, 32'h40, 1, 0, 0);
    tick;
    check("er_addr", addr, 32'h40);
    drive(0, 0, 0, 1, 32'h1111_1111, 1);
    tick;
    check("er_valid", valid, 1);
    check("er_fault", fault, 1);
    check("er_inst", inst, NOP);
    check("er_pc", pc, 32'h40);
    check("er_noreq", req, 0);
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) begin
      tick;
      check("halt_noreq", req, 0);
      check("halt_novalid", valid, 0);
    end
    drive(0, 1, 32'h80, 0, 0, 0);
    tick;
    check("hx_addr", addr, 32'h80);
    check("hx_req", req, 1);
    drive(0, 0, 0, 1, 32'h80 ^ K, 0);
    tick;
    check("hx_pc", pc, 32'h80);
    check("hx_fault", fault, 0);
    drive(0, 1, 32'h102, 1, 32'h84 ^ K, 0);
    tick;
    check("ma_noreq", req, 0);
    check("ma_valid0", valid, 0);
    drive(0, 0, 0, 0, 0, 0);
    tick;
    check("ma_valid", valid, 1);
    check("ma_fault", fault, 1);
    check("ma_pc", pc, 32'h102);
    check("ma_inst", inst, NOP);
    check("ma_halt_req", req, 0);
    drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    tick;
    check("wr_addr0", addr, 32'hFFFF_FFFC);
    drive(0, 0, 0, 1, 32'hFFFF_FFFC ^ K, 0);
    tick;
    check("wr_addr1", addr, 32'h0);
    check("wr_pc", pc, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0, 0, 0);
    #2 rstn = 1'b0;
    #1 check("ar_req", req, 0);
    check("ar_valid", valid, 0);
    drive(0, 0, 0, 1, 32'h1234_5678, 0);
    repeat (2) tick;
    rstn = 1'b1;
    check("ar_idle_req", req, 0);
    tick;
    check("ar_addr", addr, 32'h0);
    check("ar_valid2", valid, 0);
    pend = 0; halted = 0; prev_redir = 0; pend_addr = 0; exp_pc = 0;
    for (int c = 0; c < 3000; c++) begin
      if (pend) begin
        check("bus_hold_req", req, 1);
        check("bus_hold_addr", addr, pend_addr);
      end
      if (prev_redir) check("redir_valid", valid, 0);
      if (halted) begin
        check("halt_req", req, 0);
        check("halt_valid", valid, 0);
      end
      s = ($urandom % 4) == 0;
      r = ($urandom % 24) == 0;
      sel = $urandom % 4;
      tgt = $urandom_range(0, 1023) << 2;
      tgt = sel == 0 ? 32'hFFFF_FFF8 : sel == 1 ? (tgt | 32'd2) : tgt;
      a = 0;
      if (req) begin
        if (!pend) lat = $urandom % 4;
        a = lat == 0;
        if (!a) lat--;
      end
      d = addr ^ K;
      e = addr[7:2] == 6'h2A;
      if (valid && !s) begin
        exp_f = (|exp_pc[1:0]) || exp_pc[7:2] == 6'h2A;
        check("out_pc", pc, exp_pc);
        check("out_fault", fault, exp_f);
        check("out_inst", inst, exp_f ? NOP : exp_pc ^ K);
        exp_pc += 4;
        n_cons++;
        if (exp_f) halted = 1;
      end
      if (r) begin
        exp_pc = tgt;
        halted = 0;
      end
      pend = req && !a;
      pend_addr = addr;
      prev_redir = r;
      drive(s, r, tgt, a, d, e);
      tick;
    end
    check("progress", n_cons > 200, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
